// File: rtl/edge_cache_mc.sv
// edge_cache_mc: adjacency-matrix edge store shared by NUM_CHANNELS read channels
// through a round-robin arbiter. Define EDGE_CACHE_SYMMETRIC_EN to mirror every write.
`ifndef DEFAULT_MAX_NODES
`define DEFAULT_MAX_NODES 12
`endif
`ifndef DEFAULT_INDEX_WIDTH
`define DEFAULT_INDEX_WIDTH 4
`endif
`ifndef DEFAULT_VALUE_WIDTH
`define DEFAULT_VALUE_WIDTH 32
`endif

module edge_cache_mc #(
    parameter int MAX_NODES    = `DEFAULT_MAX_NODES,
    parameter int INDEX_WIDTH  = `DEFAULT_INDEX_WIDTH,
    parameter int VALUE_WIDTH  = `DEFAULT_VALUE_WIDTH,
    parameter int NUM_CHANNELS = 4,
    parameter logic [VALUE_WIDTH-1:0] INF_VALUE = VALUE_WIDTH'(32'h7F800000)
) (
    input  logic                                clock,
    input  logic                                reset_n,
    input  logic                                wr_en,
    input  logic [INDEX_WIDTH-1:0]              wr_from,
    input  logic [INDEX_WIDTH-1:0]              wr_to,
    input  logic [VALUE_WIDTH-1:0]              wr_data,
    output logic                                wr_ready,
    input  logic [NUM_CHANNELS-1:0]             req_valid,
    input  logic [NUM_CHANNELS*INDEX_WIDTH-1:0] req_from,
    input  logic [NUM_CHANNELS*INDEX_WIDTH-1:0] req_to,
    output logic [NUM_CHANNELS-1:0]             req_ready,
    output logic [NUM_CHANNELS-1:0]             resp_valid,
    output logic [NUM_CHANNELS*VALUE_WIDTH-1:0] resp_data,
    input  logic [NUM_CHANNELS-1:0]             resp_ready,
    output logic                                busy
);
    localparam int ADDR_W = 2 * INDEX_WIDTH;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int PTR_W  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam logic [INDEX_WIDTH:0] NODE_LIMIT = (INDEX_WIDTH+1)'(MAX_NODES);

    typedef enum logic [1:0] {CH_IDLE, CH_WAIT, CH_HOLD} ch_state_e;

    ch_state_e              state_q     [NUM_CHANNELS];
    ch_state_e              state_d     [NUM_CHANNELS];
    logic [VALUE_WIDTH-1:0] resp_data_q [NUM_CHANNELS];
    logic [VALUE_WIDTH-1:0] resp_data_d [NUM_CHANNELS];
    logic [PTR_W-1:0]       ptr_q, ptr_d;
    logic                   running_q;
    logic                   rd_oor_q, rd_oor_d;
    logic [VALUE_WIDTH-1:0] rd_data_q;
    logic [VALUE_WIDTH-1:0] mem [DEPTH];

    logic                   mem_we, mem_re;
    logic [ADDR_W-1:0]      mem_addr;
    logic [VALUE_WIDTH-1:0] mem_wdata;
    logic                   wr_accept, arb_en, grant_any, busy_ch;
    logic [PTR_W-1:0]       grant_idx, cand;
    logic [INDEX_WIDTH-1:0] g_from, g_to;
    logic                   mirror_active;
    logic [INDEX_WIDTH-1:0] mir_row, mir_col;
    logic [VALUE_WIDTH-1:0] mir_data;

    function automatic logic in_range(input logic [INDEX_WIDTH-1:0] idx);
        return {1'b0, idx} < NODE_LIMIT;
    endfunction

`ifdef EDGE_CACHE_SYMMETRIC_EN
    logic                   mirror_q, mirror_d;
    logic [INDEX_WIDTH-1:0] mir_row_q, mir_row_d, mir_col_q, mir_col_d;
    logic [VALUE_WIDTH-1:0] mir_data_q, mir_data_d;

    // Transposed entry (row=to, col=from) is written one cycle after the original.
    always_comb begin
        mirror_d   = wr_accept && (wr_from != wr_to);
        mir_row_d  = wr_to;
        mir_col_d  = wr_from;
        mir_data_d = wr_data;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mirror_q   <= 1'b0;
            mir_row_q  <= '0;
            mir_col_q  <= '0;
            mir_data_q <= '0;
        end else begin
            mirror_q   <= mirror_d;
            mir_row_q  <= mir_row_d;
            mir_col_q  <= mir_col_d;
            mir_data_q <= mir_data_d;
        end
    end

    assign mirror_active = mirror_q;
    assign mir_row       = mir_row_q;
    assign mir_col       = mir_col_q;
    assign mir_data      = mir_data_q;
`else
    assign mirror_active = 1'b0;
    assign mir_row       = '0;
    assign mir_col       = '0;
    assign mir_data      = '0;
`endif

    assign wr_ready  = running_q && !mirror_active;
    assign wr_accept = wr_en && wr_ready;
    assign arb_en    = running_q && !wr_accept && !mirror_active;
    assign busy      = busy_ch || mirror_active;

    always_comb begin
        grant_any  = 1'b0;
        grant_idx  = '0;
        cand       = '0;
        req_ready  = '0;
        ptr_d      = ptr_q;
        resp_valid = '0;
        resp_data  = '0;
        busy_ch    = 1'b0;
        // Walk channels starting at the pointer; first idle requester wins.
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            cand = PTR_W'((int'(ptr_q) + i) % NUM_CHANNELS);
            if (!grant_any && arb_en && req_valid[cand] && state_q[cand] == CH_IDLE) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
        if (grant_any) begin
            req_ready[grant_idx] = 1'b1;
            ptr_d = PTR_W'((int'(grant_idx) + 1) % NUM_CHANNELS);
        end
        g_from = req_from[grant_idx*INDEX_WIDTH +: INDEX_WIDTH];
        g_to   = req_to[grant_idx*INDEX_WIDTH +: INDEX_WIDTH];

        for (int c = 0; c < NUM_CHANNELS; c++) begin
            state_d[c]     = state_q[c];
            resp_data_d[c] = resp_data_q[c];
            case (state_q[c])
                CH_IDLE: if (req_ready[c]) state_d[c] = CH_WAIT;
                CH_WAIT: begin
                    state_d[c]     = CH_HOLD;
                    resp_data_d[c] = rd_oor_q ? INF_VALUE : rd_data_q;
                end
                CH_HOLD: if (resp_ready[c]) state_d[c] = CH_IDLE;
                default: state_d[c] = CH_IDLE;
            endcase
            resp_valid[c] = (state_q[c] == CH_HOLD);
            resp_data[c*VALUE_WIDTH +: VALUE_WIDTH] = resp_data_q[c];
            if (state_q[c] != CH_IDLE) busy_ch = 1'b1;
        end
    end

    // One RAM port: mirror write, then primary write, then the granted read.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = {g_to, g_from};
        mem_wdata = wr_data;
        mem_re    = grant_any;
        rd_oor_d  = rd_oor_q;
        if (mirror_active) begin
            mem_we    = in_range(mir_row) && in_range(mir_col);
            mem_addr  = {mir_col, mir_row};
            mem_wdata = mir_data;
        end else if (wr_accept) begin
            mem_we    = in_range(wr_from) && in_range(wr_to);
            mem_addr  = {wr_to, wr_from};
        end
        if (grant_any) rd_oor_d = !(in_range(g_from) && in_range(g_to));
    end

    always_ff @(posedge clock) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        else if (mem_re) rd_data_q <= mem[mem_addr];
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            running_q <= 1'b0;
            ptr_q     <= '0;
            rd_oor_q  <= 1'b0;
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                state_q[c]     <= CH_IDLE;
                resp_data_q[c] <= '0;
            end
        end else begin
            running_q <= 1'b1;
            ptr_q     <= ptr_d;
            rd_oor_q  <= rd_oor_d;
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                state_q[c]     <= state_d[c];
                resp_data_q[c] <= resp_data_d[c];
            end
        end
    end

endmodule

// File: tb/tb_edge_cache_mc.sv
// tb_edge_cache_mc: directed scenarios plus a randomized run of edge_cache_mc
// checked cycle by cycle against a behavioural reference model.
module tb_edge_cache_mc;
    localparam int N    = 4;
    localparam int IW   = 4;
    localparam int VW   = 32;
    localparam int MAXN = 12;
    localparam logic [VW-1:0] INF = 32'h7F800000;

    logic            clock = 1'b0;
    logic            reset_n = 1'b0;
    logic            wr_en;
    logic [IW-1:0]   wr_from, wr_to;
    logic [VW-1:0]   wr_data;
    logic            wr_ready;
    logic [N-1:0]    req_valid, req_ready, resp_valid, resp_ready;
    logic [N*IW-1:0] req_from, req_to;
    logic [N*VW-1:0] resp_data;
    logic            busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: matrix indexed [from][to], per-channel phase and held value.
    logic [VW-1:0] ref_mem [16][16];
    int            m_ph    [N];
    logic [VW-1:0] m_data  [N];
    logic [VW-1:0] m_pend  [N];
    int            m_ptr;
    bit            m_mirror;
    int            m_mr, m_mc;
    logic [VW-1:0] m_md;

    edge_cache_mc #(
        .MAX_NODES(MAXN), .INDEX_WIDTH(IW), .VALUE_WIDTH(VW),
        .NUM_CHANNELS(N), .INF_VALUE(INF)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .wr_en(wr_en), .wr_from(wr_from), .wr_to(wr_to), .wr_data(wr_data), .wr_ready(wr_ready),
        .req_valid(req_valid), .req_from(req_from), .req_to(req_to), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_ready(resp_ready), .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        wr_en = 1'b0; wr_from = '0; wr_to = '0; wr_data = '0;
        req_valid = '0; req_from = '0; req_to = '0; resp_ready = '0;
    endtask

    task automatic set_req(input int c, input int f, input int t);
        req_from[c*IW +: IW] = IW'(f);
        req_to[c*IW +: IW]   = IW'(t);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        clear_inputs();
        tick(); tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic do_write(input int f, input int t, input logic [VW-1:0] d);
        tick();
        wr_en = 1'b1; wr_from = IW'(f); wr_to = IW'(t); wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic issue_read(input int c, input int f, input int t,
                              output logic granted, output logic got_v, output logic [VW-1:0] got);
        tick();
        req_valid = N'(1 << c);
        set_req(c, f, t);
        #1;
        granted = req_ready[c];
        tick();
        req_valid = '0;
        tick();
        #1;
        got_v = resp_valid[c];
        got   = resp_data[c*VW +: VW];
        resp_ready = N'(1 << c);
        tick();
        resp_ready = '0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        clear_inputs();
        wr_en = 1'b1; req_valid = '1; resp_ready = '1;
        tick(); tick();
        #1;
        n_checks++; if (req_ready !== '0) begin n_fail++; $display("FAIL reset_req_ready: got %b want 0", req_ready); end
        n_checks++; if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL reset_wr_ready: got %b want 0", wr_ready); end
        n_checks++; if (resp_valid !== '0) begin n_fail++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
        n_checks++; if (resp_data !== '0) begin n_fail++; $display("FAIL reset_resp_data: got %h want 0", resp_data); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        clear_inputs();
        reset_n = 1'b1;
        tick();
        #1;
        n_checks++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_wr_ready: got %b want 1", wr_ready); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL post_reset_busy: got %b want 0", busy); end
    endtask

    task automatic test_write_read();
        do_write(2, 5, 32'h40400000);
        tick();
        req_valid = 4'b0001;
        set_req(0, 2, 5);
        #1;
        n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL wr_rd_grant: got %b want 0001", req_ready); end
        tick();
        req_valid = '0;
        #1;
        n_checks++; if (resp_valid !== 4'b0000) begin n_fail++; $display("FAIL wr_rd_wait_valid: got %b want 0000", resp_valid); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL wr_rd_wait_busy: got %b want 1", busy); end
        tick();
        #1;
        n_checks++; if (resp_valid !== 4'b0001) begin n_fail++; $display("FAIL wr_rd_valid: got %b want 0001", resp_valid); end
        n_checks++; if (resp_data[0 +: VW] !== 32'h40400000) begin n_fail++; $display("FAIL wr_rd_data: got %h want 40400000", resp_data[0 +: VW]); end
        for (int i = 0; i < 3; i++) begin
            tick();
            #1;
            n_checks++; if (resp_valid[0] !== 1'b1 || resp_data[0 +: VW] !== 32'h40400000) begin
                n_fail++; $display("FAIL wr_rd_hold: got v=%b d=%h want v=1 d=40400000", resp_valid[0], resp_data[0 +: VW]);
            end
        end
        resp_ready = 4'b0001;
        tick();
        resp_ready = '0;
        #1;
        n_checks++; if (resp_valid !== 4'b0000) begin n_fail++; $display("FAIL wr_rd_release: got %b want 0000", resp_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL wr_rd_release_busy: got %b want 0", busy); end
    endtask

    task automatic test_write_priority();
        do_write(6, 3, 32'h11111111);
        tick();
        tick();
        wr_en = 1'b1; wr_from = 4'd6; wr_to = 4'd3; wr_data = 32'h22222222;
        req_valid = 4'b0010;
        set_req(1, 6, 3);
        #1;
        n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL prio_blocked: got %b want 0000", req_ready); end
        n_checks++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL prio_wr_ready: got %b want 1", wr_ready); end
        tick();
        wr_en = 1'b0;
`ifdef EDGE_CACHE_SYMMETRIC_EN
        #1;
        n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL prio_mirror_stall: got %b want 0000", req_ready); end
        tick();
`endif
        #1;
        n_checks++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL prio_grant_next: got %b want 0010", req_ready); end
        tick();
        req_valid = '0;
        tick();
        #1;
        n_checks++; if (resp_valid[1] !== 1'b1 || resp_data[VW +: VW] !== 32'h22222222) begin
            n_fail++; $display("FAIL prio_new_data: got v=%b d=%h want v=1 d=22222222", resp_valid[1], resp_data[VW +: VW]);
        end
        resp_ready = 4'b0010;
        tick();
        resp_ready = '0;
    endtask

    task automatic test_out_of_range();
        logic g, v;
        logic [VW-1:0] d;
        issue_read(0, 13, 0, g, v, d);
        n_checks++; if (g !== 1'b1 || v !== 1'b1 || d !== INF) begin n_fail++; $display("FAIL oor_read_13_0: got g=%b v=%b d=%h want 1 1 %h", g, v, d, INF); end
        tick();
        wr_en = 1'b1; wr_from = 4'd0; wr_to = 4'd14; wr_data = 32'h3F800000;
        #1;
        n_checks++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL oor_write_accept: got %b want 1", wr_ready); end
        tick();
        wr_en = 1'b0;
        issue_read(0, 14, 0, g, v, d);
        n_checks++; if (g !== 1'b1 || v !== 1'b1 || d !== INF) begin n_fail++; $display("FAIL oor_read_14_0: got g=%b v=%b d=%h want 1 1 %h", g, v, d, INF); end
    endtask

    task automatic test_backpressure_reset();
        int g0 = 0, g1 = 0;
        tick();
        req_valid = 4'b0100;
        set_req(2, 2, 5); set_req(0, 2, 5); set_req(1, 6, 3); set_req(3, 2, 5);
        #1;
        n_checks++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL bp_grant2: got %b want 0100", req_ready); end
        tick();
        req_valid = 4'b0011;
        resp_ready = 4'b0011;
        tick();
        for (int i = 0; i < 10; i++) begin
            #1;
            n_checks++; if (resp_valid[2] !== 1'b1 || resp_data[2*VW +: VW] !== 32'h40400000) begin
                n_fail++; $display("FAIL bp_hold2 cycle %0d: got v=%b d=%h want v=1 d=40400000", i, resp_valid[2], resp_data[2*VW +: VW]);
            end
            if (req_ready[0]) g0++;
            if (req_ready[1]) g1++;
            tick();
        end
        n_checks++; if (g0 < 3 || g1 < 3) begin n_fail++; $display("FAIL bp_others_served: got g0=%0d g1=%0d want >=3 each", g0, g1); end
        req_valid = '0;
        tick(); tick(); tick();
        req_valid = 4'b1000;
        #1;
        n_checks++; if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL bp_grant3: got %b want 1000", req_ready); end
        tick();
        #1;
        n_checks++; if (resp_valid !== 4'b0100 || busy !== 1'b1) begin n_fail++; $display("FAIL bp_prereset: got v=%b busy=%b want 0100 1", resp_valid, busy); end
        reset_n = 1'b0;
        #1;
        n_checks++; if (resp_valid !== 4'b0000) begin n_fail++; $display("FAIL bp_reset_valid: got %b want 0000", resp_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL bp_reset_busy: got %b want 0", busy); end
        n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_reset_req_ready: got %b want 0000", req_ready); end
        clear_inputs();
    endtask

    task automatic test_round_robin();
        do_reset();
        req_valid = '1;
        resp_ready = '1;
        for (int c = 0; c < N; c++) set_req(c, 2, 5);
        for (int k = 0; k < 12; k++) begin
            #1;
            n_checks++; if (req_ready !== N'(1 << (k % N))) begin
                n_fail++; $display("FAIL rr_grant cycle %0d: got %b want %b", k, req_ready, N'(1 << (k % N)));
            end
            tick();
        end
        req_valid = '0;
        tick(); tick(); tick();
        resp_ready = '0;
    endtask

`ifdef EDGE_CACHE_SYMMETRIC_EN
    task automatic test_symmetric();
        logic g, v;
        logic [VW-1:0] d;
        do_reset();
        wr_en = 1'b1; wr_from = 4'd3; wr_to = 4'd7; wr_data = 32'h41200000;
        #1;
        n_checks++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL sym_accept: got %b want 1", wr_ready); end
        tick();
        req_valid = 4'b0001;
        set_req(0, 3, 7);
        #1;
        n_checks++; if (wr_ready !== 1'b0 || req_ready !== 4'b0000 || busy !== 1'b1) begin
            n_fail++; $display("FAIL sym_stall: got wr_ready=%b req_ready=%b busy=%b want 0 0000 1", wr_ready, req_ready, busy);
        end
        wr_en = 1'b0; req_valid = '0;
        issue_read(0, 3, 7, g, v, d);
        n_checks++; if (v !== 1'b1 || d !== 32'h41200000) begin n_fail++; $display("FAIL sym_read_3_7: got v=%b d=%h want 1 41200000", v, d); end
        issue_read(1, 7, 3, g, v, d);
        n_checks++; if (v !== 1'b1 || d !== 32'h41200000) begin n_fail++; $display("FAIL sym_read_7_3: got v=%b d=%h want 1 41200000", v, d); end
        tick();
        wr_en = 1'b1; wr_from = 4'd4; wr_to = 4'd4; wr_data = 32'h40000000;
        tick();
        wr_en = 1'b0;
        #1;
        n_checks++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL sym_diag_no_stall: got %b want 1", wr_ready); end
    endtask
`endif

    task automatic test_random();
        int g;
        logic [N-1:0]    exp_rr, exp_rv;
        logic [N*VW-1:0] exp_rd;
        logic            exp_wrr, exp_busy, wacc;
        do_reset();
        for (int c = 0; c < N; c++) begin m_ph[c] = 0; m_data[c] = '0; end
        m_ptr = 0; m_mirror = 0;
        for (int f = 0; f < MAXN; f++) begin
            for (int t = 0; t < MAXN; t++) begin
                logic [VW-1:0] d;
                d = $urandom();
                do_write(f, t, d);
                ref_mem[f][t] = d;
`ifdef EDGE_CACHE_SYMMETRIC_EN
                ref_mem[t][f] = d;
`endif
            end
        end
        for (int cyc = 0; cyc < 400; cyc++) begin
            tick();
            wr_en   = ($urandom_range(0, 3) == 0);
            wr_from = IW'($urandom_range(0, 13));
            wr_to   = IW'($urandom_range(0, 13));
            wr_data = $urandom();
            req_valid  = N'($urandom());
            resp_ready = N'($urandom());
            for (int c = 0; c < N; c++) set_req(c, $urandom_range(0, 13), $urandom_range(0, 13));
            #1;
            exp_wrr = !m_mirror;
            wacc    = wr_en && exp_wrr;
            g = -1;
            if (!wacc && !m_mirror) begin
                for (int k = 0; k < N; k++) begin
                    int c;
                    c = (m_ptr + k) % N;
                    if (g < 0 && req_valid[c] && m_ph[c] == 0) g = c;
                end
            end
            exp_rr = '0;
            if (g >= 0) exp_rr[g] = 1'b1;
            exp_busy = m_mirror;
            for (int c = 0; c < N; c++) begin
                exp_rv[c] = (m_ph[c] == 2);
                exp_rd[c*VW +: VW] = m_data[c];
                if (m_ph[c] != 0) exp_busy = 1'b1;
            end
            n_checks++; if (req_ready !== exp_rr) begin n_fail++; $display("FAIL rnd_req_ready cycle %0d: got %b want %b", cyc, req_ready, exp_rr); end
            n_checks++; if (wr_ready !== exp_wrr) begin n_fail++; $display("FAIL rnd_wr_ready cycle %0d: got %b want %b", cyc, wr_ready, exp_wrr); end
            n_checks++; if (resp_valid !== exp_rv) begin n_fail++; $display("FAIL rnd_resp_valid cycle %0d: got %b want %b", cyc, resp_valid, exp_rv); end
            n_checks++; if (resp_data !== exp_rd) begin n_fail++; $display("FAIL rnd_resp_data cycle %0d: got %h want %h", cyc, resp_data, exp_rd); end
            n_checks++; if (busy !== exp_busy) begin n_fail++; $display("FAIL rnd_busy cycle %0d: got %b want %b", cyc, busy, exp_busy); end
            if (m_mirror) begin
                if (m_mr < MAXN && m_mc < MAXN) ref_mem[m_mr][m_mc] = m_md;
                m_mirror = 0;
            end else if (wacc) begin
                if (int'(wr_from) < MAXN && int'(wr_to) < MAXN) ref_mem[wr_from][wr_to] = wr_data;
`ifdef EDGE_CACHE_SYMMETRIC_EN
                if (wr_from != wr_to) begin
                    m_mirror = 1; m_mr = int'(wr_to); m_mc = int'(wr_from); m_md = wr_data;
                end
`endif
            end
            for (int c = 0; c < N; c++) begin
                if (m_ph[c] == 2 && resp_ready[c]) m_ph[c] = 0;
                else if (m_ph[c] == 1) begin m_ph[c] = 2; m_data[c] = m_pend[c]; end
            end
            if (g >= 0) begin
                int f, t;
                f = int'(req_from[g*IW +: IW]);
                t = int'(req_to[g*IW +: IW]);
                m_ph[g]   = 1;
                m_pend[g] = (f >= MAXN || t >= MAXN) ? INF : ref_mem[f][t];
                m_ptr     = (g + 1) % N;
            end
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_write_read();
        test_write_priority();
        test_out_of_range();
        test_backpressure_reset();
        test_round_robin();
`ifdef EDGE_CACHE_SYMMETRIC_EN
        test_symmetric();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
